period_meter: RTL
=================

Name: period_meter

Overview:
- Measures the period and high time of a slow, free-running square wave, counted in cycles of the fast system clock.
- Typical source is the toggled output of the stopwatch clock divider.
- Recovers the divide ratio the divider was built with, so the bench and on-board self-test can confirm the 1 kHz timebase before the stopwatch FSM is enabled.
- Single-shot: one measurement per start request, with a timeout for a dead input.

Parameters:
- CNT_WIDTH, 32: width of the period, high-time and timeout counters.
- TIMEOUT, 200000: fast cycles allowed in ARM or MEASURE before aborting. Must be < 2^CNT_WIDTH.

Ports:
- clk_in  input  1  fast system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset; block is in reset while low.
- sig_in  input  1  slow square wave, asynchronous to clk_in.
- start  input  1  one-cycle request to begin a measurement.
- busy  output  1  high while settling, armed or measuring.
- valid  output  1  one-cycle pulse when results update.
- timeout  output  1  sticky flag: the last measurement aborted. Valid with valid; held until the next accepted start.
- period  output  CNT_WIDTH  clk_in cycles between two consecutive rising edges of sig_in.
- high_time  output  CNT_WIDTH  clk_in cycles sig_in was high within that period.

Behaviour:
- Reset (reset low, asynchronous) clears all outputs, counters and synchronizer flops to 0. State goes to SETTLE.
- Input path: sig_in passes through a 2-flop synchronizer (s1, s2), then an edge register s3.
  - rise = s2 & ~s3.
  - rise asserts 3 clk_in cycles after a sig_in rising edge.
- FSM states:
  - SETTLE: counts 3 cycles, busy = 1, start ignored, then goes to IDLE. This suppresses a false rise when sig_in is high at reset release.
  - IDLE: busy = 0. On start: clear timeout, clear tcnt, go to ARM.
  - ARM: busy = 1, tcnt increments each cycle.
    - On rise: cnt <= 1, hcnt <= 1, tcnt <= 0, go to MEASURE.
  - MEASURE: busy = 1, tcnt increments. cnt increments every cycle; hcnt increments in cycles where s2 = 1.
    - On rise: period <= cnt, high_time <= hcnt, valid = 1 next cycle, go to IDLE.
- Result identity: for rises at cycles t0 and t0+P, period = P, and high_time = number of cycles in [t0, t0+P-1] with s2 = 1.
- Timeout: in ARM or MEASURE, when tcnt == TIMEOUT-1 and rise = 0:
  - period <= 0, high_time <= 0, timeout <= 1, valid = 1 next cycle, go to IDLE.
  - If rise and the timeout condition occur in the same cycle, rise wins.
- Outputs are registered. period and high_time hold their value until the next valid.
- valid is high for exactly one cycle per accepted start.
- start handling:
  - start while busy is ignored; it is neither queued nor restarts the measurement.
  - start in the same cycle valid is high is accepted, because the FSM is in IDLE.
- Counter arithmetic: unsigned, no wrap possible, since counting is bounded by TIMEOUT < 2^CNT_WIDTH.
- Reset asserted mid-measurement: everything is cleared immediately, and no valid is issued for the aborted run.
- A constant-high or constant-low sig_in always ends in timeout.
- A glitch shorter than one clk_in cycle may be missed. This is acceptable.

Test Plan:
- Reset then settle: hold reset low 5 cycles with sig_in = 1, release -> busy = 1 for 3 cycles, then 0; no valid; outputs all 0; no false rise after start until a real edge.
- Divider-driven: sig_in = 50% wave toggling every 4 clk_in cycles, pulse start -> single valid with period = 8, high_time = 4, timeout = 0.
- Asymmetric wave: sig_in high 3 cycles, low 7 cycles, repeating -> period = 10, high_time = 3.
- Timeout: TIMEOUT = 100, sig_in stuck 0, pulse start at cycle c -> valid at cycle c+101 with timeout = 1, period = 0, high_time = 0; next start clears timeout.
- Start while busy: second start pulse during MEASURE -> ignored, exactly one valid; start in the same cycle as valid -> new measurement begins (busy = 1 next cycle).
- Mid-op reset: pull reset low during MEASURE -> busy, valid, period, high_time = 0 immediately, no valid after release; after settling, a fresh start measures correctly (period = 8).

Source files
------------

// File: rtl/period_meter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | period_meter_if : measurement request / result bundle of period_meter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface period_meter_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 sig_in;
    logic                 start;
    logic                 busy;
    logic                 valid;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;

    modport master (
        output sig_in,
        output start,
        input  busy,
        input  valid,
        input  timeout,
        input  period,
        input  high_time
    );

    modport slave (
        input  sig_in,
        input  start,
        output busy,
        output valid,
        output timeout,
        output period,
        output high_time
    );
endinterface
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | period_meter : single-shot period / high-time meter for a slow square wave|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module period_meter #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 200000
) (
    input  logic          clk_in,
    input  logic          reset,
    period_meter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ARM     = 2'd2,
        ST_MEASURE = 2'd3
    } state_t;

    localparam logic [1:0]           c_SETTLE_LAST = 2'd3;
    localparam logic [CNT_WIDTH-1:0] c_TCNT_LAST   = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_ONE         = CNT_WIDTH'(1);

    logic                 s1_q, s2_q, s3_q;
    state_t               state_q;
    logic [1:0]           settle_q;
    logic [CNT_WIDTH-1:0] cnt_q, hcnt_q, tcnt_q;
    logic [CNT_WIDTH-1:0] period_q, high_q;
    logic                 busy_q, valid_q, timeout_q;

    logic                 w_rise;
    logic                 w_tmo_hit;
    logic [CNT_WIDTH-1:0] tcnt_d, cnt_d, hcnt_d;

    // sig_in is asynchronous: two flops for metastability, a third for edge detect
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign w_rise    = s2_q & ~s3_q;
    assign w_tmo_hit = (tcnt_q == c_TCNT_LAST) & ~w_rise;
    assign tcnt_d    = tcnt_q + c_ONE;
    assign cnt_d     = cnt_q + c_ONE;
    assign hcnt_d    = hcnt_q + {{(CNT_WIDTH-1){1'b0}}, s2_q};

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SETTLE;
            settle_q  <= 2'd0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            tcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                // Lets the synchronizer fill so a high sig_in at reset release is not seen as a rise
                ST_SETTLE: begin
                    if (settle_q == c_SETTLE_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        busy_q   <= 1'b1;
                        settle_q <= settle_q + 2'd1;
                    end
                end
                ST_IDLE: begin
                    if (bus.start) begin
                        timeout_q <= 1'b0;
                        tcnt_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_rise) begin
                        cnt_q   <= c_ONE;
                        hcnt_q  <= c_ONE;
                        tcnt_q  <= '0;
                        state_q <= ST_MEASURE;
                    end else if (w_tmo_hit) begin
                        period_q  <= '0;
                        high_q    <= '0;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_d;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        period_q <= cnt_q;
                        high_q   <= hcnt_q;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (w_tmo_hit) begin
                        period_q  <= '0;
                        high_q    <= '0;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_d;
                        cnt_q  <= cnt_d;
                        hcnt_q <= hcnt_d;
                    end
                end
                default: state_q <= ST_SETTLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.period    = period_q;
    assign bus.high_time = high_q;

endmodule
`default_nettype wire
